// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES request scheduler.
//   sched_state_e : scheduler FSM states
//   id_width()    : width of a requester index, never less than one bit
//   rr_next()     : round-robin pick, the first set bit scanning upward from
//                   last+1 and wrapping modulo num_req
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } sched_state_e;

  localparam int MAX_REQ  = 16;
  localparam int RR_IDX_W = 4;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // The scan runs from the largest offset down to the smallest, so the
  // nearest set bit after 'last' is the one left in 'gnt'. With nothing set,
  // 'last' is returned and the caller is expected to qualify it with 'any'.
  function automatic logic [RR_IDX_W-1:0] rr_next(
    input logic [MAX_REQ-1:0]  valid,
    input logic [RR_IDX_W-1:0] last,
    input int                  num_req
  );
    logic [RR_IDX_W-1:0] gnt;
    logic [RR_IDX_W-1:0] idx;
    gnt = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        idx = RR_IDX_W'((int'(last) + k) % num_req);
        if (valid[idx]) gnt = idx;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Purely combinational round-robin arbiter.
//   req        : request bits, one per requester
//   last       : index of the most recently served requester
//   en         : when low, no grant is issued
//   gnt_onehot : one-hot grant (all zero when en is low or nothing requests)
//   gnt_idx    : binary index of the winner (qualify it with 'any')
//   any        : at least one request is pending
module aes_rr_arbiter
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDW-1:0]     gnt_idx,
  output logic               any
);

  logic [RR_IDX_W-1:0] pick;

  assign pick    = rr_next(MAX_REQ'(req), RR_IDX_W'(last), NUM_REQ);
  assign gnt_idx = IDW'(pick);
  assign any     = |req;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    gnt_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_onehot[i] = en && any && (pick == RR_IDX_W'(i));
    end
  end

endmodule

// File: rtl/aes_enc_sched.sv
// Shares one aes_encrypt core among NUM_REQ requesters. Requests are accepted
// one at a time in round-robin order, forwarded to the core with a one-cycle
// load pulse, and the ciphertext (or a timeout error) is returned tagged with
// the requester index.
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : per-requester handshake (ready is one-hot)
//   req_key, req_pt                : per-requester key and plaintext
//   rsp_valid/rsp_ready            : result handshake
//   rsp_id, rsp_ct, rsp_err        : owner index, ciphertext (0 on error), timeout flag
//   core_load, core_key, core_pt   : drive to the encrypt core
//   core_ct_valid, core_ct         : result from the encrypt core
module aes_enc_sched
  import aes_sched_pkg::*;
#(
  parameter int NK      = 4,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][32*NK-1:0]    req_key,
  input  logic [NUM_REQ-1:0][127:0]        req_pt,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [id_width(NUM_REQ)-1:0]     rsp_id,
  output logic [127:0]                     rsp_ct,
  output logic                             rsp_err,
  output logic                             core_load,
  output logic [32*NK-1:0]                 core_key,
  output logic [127:0]                     core_pt,
  input  logic                             core_ct_valid,
  input  logic [127:0]                     core_ct
);

  localparam int             IDW        = id_width(NUM_REQ);
  localparam int             TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

  sched_state_e   state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] gnt_idx;
  logic [TW-1:0]  timer;
  logic           any_req;
  logic           arb_en;

  // Grants are only offered in IDLE and never while reset is being sampled,
  // so a requester is never told it was accepted when nothing is captured.
  assign arb_en = (state == IDLE) && !rst;

  aes_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (req_valid),
    .last       (last),
    .en         (arb_en),
    .gnt_onehot (req_ready),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the key/plaintext capture registers are reset like any other
      // state because the outputs they drive must read zero after reset.
      state     <= IDLE;
      last      <= IDW'(NUM_REQ - 1);
      timer     <= '0;
      core_load <= 1'b0;
      core_key  <= '0;
      core_pt   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_ct    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      core_load <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            core_key  <= req_key[gnt_idx];
            core_pt   <= req_pt[gnt_idx];
            rsp_id    <= gnt_idx;
            core_load <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // core_ct_valid is only looked at here, so a level left over from
          // an earlier or aborted operation is never mistaken for a result.
          if (core_ct_valid) begin
            rsp_ct    <= core_ct;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timer == TIMER_LAST) begin
            rsp_ct    <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            last      <= rsp_id;
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_sched.sv
// Bench for aes_enc_sched: a behavioural core stub with programmable latency,
// a transaction-level expectation model compared every cycle, and directed
// scenarios with literal expected values.
module tb_aes_enc_sched;

  localparam int N   = 4;
  localparam int NK  = 4;
  localparam int TO  = 8;
  localparam int KW  = 32 * NK;
  localparam int IDW = 2;

  // Known-answer vectors, byte-reversed packing as used by the requesters.
  localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] P1 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] K2 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] P2 = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] C2 = 128'h320b6a19978511dcfb09dc021d842539;

  logic                     clk;
  logic                     rst;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [N-1:0][KW-1:0]     req_key;
  logic [N-1:0][127:0]      req_pt;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [127:0]             rsp_ct;
  logic                     rsp_err;
  logic                     core_load;
  logic [KW-1:0]            core_key;
  logic [127:0]             core_pt;
  logic                     core_ct_valid;
  logic [127:0]             core_ct;

  aes_enc_sched #(
    .NK      (NK),
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_key       (req_key),
    .req_pt        (req_pt),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_ct        (rsp_ct),
    .rsp_err       (rsp_err),
    .core_load     (core_load),
    .core_key      (core_key),
    .core_pt       (core_pt),
    .core_ct_valid (core_ct_valid),
    .core_ct       (core_ct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- core stub ----------------
  // Encrypt table for the known vectors, otherwise an arbitrary mix.
  function automatic logic [127:0] stub_f(input logic [127:0] k, input logic [127:0] p);
    if (k == K1 && p == P1) return C1;
    if (k == K2 && p == P2) return C2;
    return {p[63:0], p[127:64]} ^ k ^ 128'h0123456789abcdeffedcba9876543210;
  endfunction

  int           stub_lat  = 3;
  logic         stub_mute = 1'b0;
  int           stub_cnt  = 0;
  logic [127:0] s_key, s_pt;

  initial begin
    core_ct_valid = 1'b0;
    core_ct       = '0;
  end

  // Result appears stub_lat cycles after the load and is then held high
  // until the next load, like a core that leaves its valid level up.
  always @(posedge clk) begin
    if (core_load) begin
      core_ct_valid <= 1'b0;
      stub_cnt      <= stub_lat;
      s_key         <= core_key;
      s_pt          <= core_pt;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_mute) begin
        core_ct_valid <= 1'b1;
        core_ct       <= stub_f(s_key, s_pt);
      end
    end
  end

  // ---------------- expectation model ----------------
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  initial begin
    bit           m_busy  = 0;
    bit           m_clean = 1;
    int           m_last  = N - 1;
    int           m_tacc  = 0;
    int           m_trsp  = 0;
    int           m_id    = 0;
    logic [127:0] m_key   = '0;
    logic [127:0] m_pt    = '0;
    logic [127:0] m_ct    = '0;
    logic         m_err   = 1'b0;
    forever begin
      int           g;
      logic [N-1:0] exp_ready;
      bit           exp_rv;
      @(negedge clk);
      if (rst) begin
        check("req_ready_in_reset", 256'(req_ready), 256'(0));
        m_busy  = 0;
        m_clean = 1;
        m_last  = N - 1;
      end else begin
        g         = rr_pick(req_valid, m_last);
        exp_ready = (!m_busy && g >= 0) ? N'(1) << g : '0;
        exp_rv    = m_busy && cyc >= m_trsp;
        check("req_ready", 256'(req_ready), 256'(exp_ready));
        check("core_load", 256'(core_load), 256'(m_busy && cyc == m_tacc + 1));
        check("rsp_valid", 256'(rsp_valid), 256'(exp_rv));
        if (exp_rv) begin
          check("rsp_id", 256'(rsp_id), 256'(m_id));
          check("rsp_ct", 256'(rsp_ct), 256'(m_ct));
          check("rsp_err", 256'(rsp_err), 256'(m_err));
        end
        if (m_clean) begin
          check("core_key_zero", 256'(core_key), 256'(0));
          check("core_pt_zero", 256'(core_pt), 256'(0));
          check("rsp_id_zero", 256'(rsp_id), 256'(0));
          check("rsp_ct_zero", 256'(rsp_ct), 256'(0));
          check("rsp_err_zero", 256'(rsp_err), 256'(0));
        end else begin
          check("core_key", 256'(core_key), 256'(m_key));
          check("core_pt", 256'(core_pt), 256'(m_pt));
        end
        if (exp_rv && rsp_ready) begin
          m_busy = 0;
          m_last = m_id;
        end else if (!m_busy && g >= 0) begin
          m_busy  = 1;
          m_clean = 0;
          m_tacc  = cyc;
          m_id    = g;
          m_key   = req_key[g];
          m_pt    = req_pt[g];
          // Load at T+1, WAIT from T+2; a result seen in WAIT answers one
          // cycle later, and the last WAIT cycle is the TIMEOUT-th.
          if (!stub_mute && stub_lat <= TO - 1) begin
            m_trsp = cyc + 3 + stub_lat;
            m_ct   = stub_f(m_key, m_pt);
            m_err  = 1'b0;
          end else begin
            m_trsp = cyc + 2 + TO;
            m_ct   = '0;
            m_err  = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- monitor for directed checks ----------------
  int           q_id[$];
  logic [127:0] q_ct[$];
  logic         q_err[$];
  int           n_loads = 0;
  int           t_load  = 0;
  int           t_rv    = 0;

  initial begin
    logic rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        q_id.push_back(int'(rsp_id));
        q_ct.push_back(rsp_ct);
        q_err.push_back(rsp_err);
      end
      if (core_load) begin
        n_loads++;
        t_load = cyc;
      end
      if (rsp_valid && !rv_prev) t_rv = cyc;
      rv_prev = rsp_valid;
    end
  end

  task automatic clear_mon();
    q_id.delete();
    q_ct.delete();
    q_err.delete();
    n_loads = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic request(input int i, input logic [127:0] key, input logic [127:0] pt);
    bit got = 0;
    req_key[i]   = key;
    req_pt[i]    = pt;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
    end
    check("grant_seen", 256'(got), 256'(1));
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp();
    bit got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) got = 1;
    end
    check("rsp_seen", 256'(got), 256'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int n);
    for (int k = 0; k < 400 && q_id.size() < n; k++) tick(1);
    check("rsp_count", 256'(q_id.size()), 256'(n));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int lat_tab[2] = '{7, 8};

    rst       = 1'b1;
    req_valid = '0;
    req_key   = '0;
    req_pt    = '0;
    rsp_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    check("reset_rsp_valid", 256'(rsp_valid), 256'(0));
    check("reset_core_load", 256'(core_load), 256'(0));

    // Single known-answer request from requester 0.
    clear_mon();
    stub_lat = 5;
    request(0, K1, P1);
    wait_rsp();
    check("kat_count", 256'(q_id.size()), 256'(1));
    if (q_id.size() > 0) begin
      check("kat_ct", 256'(q_ct[0]), 256'(C1));
      check("kat_id", 256'(q_id[0]), 256'(0));
      check("kat_err", 256'(q_err[0]), 256'(0));
    end
    check("kat_single_load", 256'(n_loads), 256'(1));

    // Round robin with everyone continuously requesting.
    reset_dut();
    clear_mon();
    stub_lat = 2;
    for (int i = 0; i < N; i++) begin
      req_key[i] = {$urandom, $urandom, $urandom, $urandom};
      req_pt[i]  = {$urandom, $urandom, $urandom, $urandom};
    end
    req_valid = '1;
    wait_count(5);
    req_valid = '0;
    tick(4);
    for (int i = 0; i < 5 && i < q_id.size(); i++) begin
      check($sformatf("rr_order_%0d", i), 256'(q_id[i]), 256'(exp_rr[i]));
    end

    // Response backpressure with a second requester waiting.
    reset_dut();
    clear_mon();
    rsp_ready = 1'b0;
    fork
      request(1, 128'h11, 128'h1111);
      request(3, 128'h33, 128'h3333);
    join_none
    for (int k = 0; k < 100 && !rsp_valid; k++) tick(1);
    tick(10);
    check("bp_no_handshake", 256'(q_id.size()), 256'(0));
    rsp_ready = 1'b1;
    wait_count(2);
    wait fork;
    if (q_id.size() == 2) begin
      check("bp_first_id", 256'(q_id[0]), 256'(1));
      check("bp_second_id", 256'(q_id[1]), 256'(3));
    end

    // Core never answers: timeout after TIMEOUT cycles in WAIT.
    clear_mon();
    stub_mute = 1'b1;
    request(2, 128'h22, 128'h2222);
    wait_rsp();
    stub_mute = 1'b0;
    if (q_id.size() == 1) begin
      check("to_err", 256'(q_err[0]), 256'(1));
      check("to_ct", 256'(q_ct[0]), 256'(0));
      check("to_id", 256'(q_id[0]), 256'(2));
    end
    check("to_latency", 256'(t_rv - t_load), 256'(TO + 1));

    // Result in the last WAIT cycle wins; one cycle later is a timeout.
    for (int j = 0; j < 2; j++) begin
      clear_mon();
      stub_lat = lat_tab[j];
      request(1, 128'h5, 128'h77);
      wait_rsp();
      if (q_err.size() == 1) begin
        check($sformatf("edge_err_lat%0d", lat_tab[j]), 256'(q_err[0]), 256'(j));
      end
    end

    // Reset while waiting; the late core result must be ignored.
    clear_mon();
    stub_lat = 6;
    request(1, 128'h99, 128'h9999);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(12);
    check("rst_wait_no_rsp", 256'(q_id.size()), 256'(0));
    check("rst_wait_rsp_valid", 256'(rsp_valid), 256'(0));
    check("rst_wait_core_key", 256'(core_key), 256'(0));
    stub_lat = 3;
    request(2, 128'habc, 128'hdef);
    wait_rsp();
    if (q_id.size() == 1) check("rst_next_id", 256'(q_id[0]), 256'(2));

    // Stale valid level from the previous operation is still high.
    clear_mon();
    check("stale_level_present", 256'(core_ct_valid), 256'(1));
    stub_lat = 4;
    request(0, K2, P2);
    wait_rsp();
    if (q_ct.size() == 1) check("stale_ct", 256'(q_ct[0]), 256'(C2));

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
